// File: rtl/snn_neuron_sync_if.sv
// snn_neuron_sync_if: synapse/spike handshake bundle; slave is the neuron side
interface snn_neuron_sync_if #(
  parameter int N_IN     = 4,
  parameter int W_WEIGHT = 8,
  parameter int W_POT    = 16
);
  logic [N_IN-1:0]          in_req;
  logic [N_IN-1:0]          in_ack;
  logic [N_IN*W_WEIGHT-1:0] in_weight;
  logic                     out_req;
  logic                     out_ack;
  logic [W_POT-1:0]         potential;
  logic [2:0]               state_o;
  modport master (output in_req, in_weight, out_ack, input in_ack, out_req, potential, state_o);
  modport slave  (input in_req, in_weight, out_ack, output in_ack, out_req, potential, state_o);
endinterface

// File: rtl/snn_neuron_sync.sv
// snn_neuron_sync: clocked leaky integrate-and-fire neuron with refractory period and saturation
// Leak term enabled by defining SNN_NEURON_LEAK_EN.
module snn_neuron_sync #(
  parameter int N_IN           = 4,
  parameter int W_WEIGHT       = 8,
  parameter int W_POT          = 16,
  parameter int THRESHOLD      = 100,
  parameter int LEAK_SHIFT     = 4,
  parameter int REFRACT_CYCLES = 3
) (
  input logic clk,
  input logic rst_n,
  snn_neuron_sync_if.slave b
);
`ifdef SNN_NEURON_LEAK_EN
  localparam bit LEAK_EN = 1'b1;
`else
  localparam bit LEAK_EN = 1'b0;
`endif
  localparam int WG = W_WEIGHT + $clog2(N_IN) + 1;
  localparam int WS = (W_POT + 1 > WG) ? W_POT + 1 : WG;
  localparam int WR = WS + 1;
  localparam int CW = REFRACT_CYCLES > 1 ? $clog2(REFRACT_CYCLES) : 1;
  localparam logic signed [WR-1:0] PMAX = WR'((longint'(1) <<< (W_POT - 1)) - 1);
  localparam logic signed [WR-1:0] PMIN = -PMAX - WR'(1);
  localparam logic signed [W_POT-1:0] TH = W_POT'(THRESHOLD);
  typedef enum logic [2:0] {IDLE, INTEG, CHECK, FIRE, FIRE_RTZ, REFRACT} state_t;
  state_t state_q, state_d;
  logic [N_IN-1:0] ack_q, ack_d, pend;
  logic signed [WS-1:0] sum_q, sum_d, sum_c;
  logic signed [W_POT-1:0] pot_q, pot_d, leak;
  logic signed [WR-1:0] raw;
  logic oreq_q, oreq_d, fire, go_fire;
  logic [CW-1:0] cnt_q, cnt_d;
  assign pend = b.in_req & ~ack_q;
  assign fire = pot_q >= TH;
  assign leak = LEAK_EN ? pot_q >>> LEAK_SHIFT : '0;
  assign raw = WR'(pot_q) - WR'(leak) + WR'(sum_q);
  assign go_fire = state_q == CHECK && state_d == FIRE;
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < N_IN; i++)
      sum_c = sum_c + (pend[i] ? WS'($signed(b.in_weight[i*W_WEIGHT +: W_WEIGHT])) : '0);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = |pend ? INTEG : IDLE;
      INTEG:    state_d = CHECK;
      // a stale out_ack must not overlap the rising out_req
      CHECK:    state_d = !fire ? IDLE : b.out_ack ? CHECK : FIRE;
      FIRE:     state_d = b.out_ack ? FIRE_RTZ : FIRE;
      FIRE_RTZ: state_d = b.out_ack ? FIRE_RTZ : REFRACT_CYCLES == 0 ? IDLE : REFRACT;
      REFRACT:  state_d = cnt_q == '0 ? IDLE : REFRACT;
      default:  state_d = IDLE;
    endcase
  end
  always_comb begin
    ack_d  = (ack_q & b.in_req) | (state_q == IDLE ? pend : '0);
    sum_d  = state_q == IDLE && |pend ? sum_c : sum_q;
    pot_d  = state_q == INTEG ? (raw > PMAX ? PMAX[W_POT-1:0] : raw < PMIN ? PMIN[W_POT-1:0] : raw[W_POT-1:0])
           : go_fire ? '0 : pot_q;
    oreq_d = go_fire | (oreq_q & !(state_q == FIRE && b.out_ack));
    cnt_d  = state_q == FIRE_RTZ && state_d == REFRACT ? CW'(REFRACT_CYCLES - 1)
           : state_q == REFRACT && cnt_q != '0 ? cnt_q - CW'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ack_q  <= '0;
      sum_q  <= '0;
      pot_q  <= '0;
      oreq_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      ack_q  <= ack_d;
      sum_q  <= sum_d;
      pot_q  <= pot_d;
      oreq_q <= oreq_d;
      cnt_q  <= cnt_d;
    end
  assign b.in_ack    = ack_q;
  assign b.out_req   = oreq_q;
  assign b.potential = pot_q;
  assign b.state_o   = state_q;
endmodule

// File: tb/tb_snn_neuron_sync.sv
// tb_snn_neuron_sync: scoreboard bench for the clocked LIF neuron (default, saturating, leaky variants)
module tb_snn_neuron_sync;
`ifdef SNN_NEURON_LEAK_EN
  localparam bit LEAK = 1'b1;
`else
  localparam bit LEAK = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  longint q_exp[$];
  longint mpot, exp_v, got;
  bit ok;
  snn_neuron_sync_if #(.N_IN(4), .W_WEIGHT(8), .W_POT(16)) a();
  snn_neuron_sync_if #(.N_IN(4), .W_WEIGHT(8), .W_POT(8))  s();
  snn_neuron_sync_if #(.N_IN(4), .W_WEIGHT(8), .W_POT(16)) l();
  snn_neuron_sync #(.N_IN(4), .W_WEIGHT(8), .W_POT(16), .THRESHOLD(100), .LEAK_SHIFT(4), .REFRACT_CYCLES(3))
    u_a (.clk(clk), .rst_n(rst_n), .b(a.slave));
  snn_neuron_sync #(.N_IN(4), .W_WEIGHT(8), .W_POT(8), .THRESHOLD(127), .LEAK_SHIFT(4), .REFRACT_CYCLES(3))
    u_s (.clk(clk), .rst_n(rst_n), .b(s.slave));
  snn_neuron_sync #(.N_IN(4), .W_WEIGHT(8), .W_POT(16), .THRESHOLD(100), .LEAK_SHIFT(2), .REFRACT_CYCLES(3))
    u_l (.clk(clk), .rst_n(rst_n), .b(l.slave));

  function automatic longint integ(input longint p, input longint w, input int sh, input int wp);
    longint r, hi;
    hi = (longint'(1) <<< (wp - 1)) - 1;
    r = p + w - (LEAK ? (p >>> sh) : 0);
    return r > hi ? hi : r < -hi - 1 ? -hi - 1 : r;
  endfunction

  task automatic a_send(input logic [3:0] m, input logic [31:0] w, output bit k);
    a.in_weight = w;
    a.in_req = a.in_req | m;
    k = 1'b0;
    for (int n = 0; n < 40 && !k; n++) begin
      @(negedge clk);
      k = (a.in_ack & m) == m;
    end
  endtask

  task automatic a_wait(input logic [2:0] st, output bit k);
    k = 1'b0;
    for (int n = 0; n < 40 && !k; n++) begin
      @(negedge clk);
      k = a.state_o == st;
    end
  endtask

  task automatic s_send(input logic [7:0] w, output bit k);
    s.in_weight = {24'd0, w};
    s.in_req = 4'b0001;
    k = 1'b0;
    for (int n = 0; n < 40 && !k; n++) begin
      @(negedge clk);
      k = s.in_ack[0];
    end
  endtask

  task automatic l_send(input logic [7:0] w, output bit k);
    l.in_weight = {24'd0, w};
    l.in_req = 4'b0001;
    k = 1'b0;
    for (int n = 0; n < 40 && !k; n++) begin
      @(negedge clk);
      k = l.in_ack[0];
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (a.state_o !== 3'd0 || a.potential !== 16'd0 || a.out_req !== 1'b0 || a.in_ack !== 4'd0) begin
      errors++;
      $display("FAIL reset_a state=%0d pot=%0d oreq=%b ack=%b required 0/0/0/0", a.state_o, a.potential, a.out_req, a.in_ack);
    end
    checks++;
    if (s.state_o !== 3'd0 || s.potential !== 8'd0 || l.state_o !== 3'd0 || l.potential !== 16'd0) begin
      errors++;
      $display("FAIL reset_sl s_state=%0d s_pot=%0d l_state=%0d l_pot=%0d required 0", s.state_o, s.potential, l.state_o, l.potential);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_integrate_fire;
    int n;
    mpot = 0;
    for (int k = 0; k < 3; k++) begin
      a_send(4'b0001, 32'd40, ok);
      checks++;
      if (!ok || a.state_o !== 3'd1) begin
        errors++;
        $display("FAIL accept%0d state=%0d ack=%b required state=1 ack0=1", k, a.state_o, a.in_ack);
      end
      q_exp.push_back(integ(mpot, 40, 4, 16));
      a.in_req[0] = 1'b0;
      @(negedge clk);
      exp_v = q_exp.pop_front();
      got = longint'($signed(a.potential));
      checks++;
      if (a.state_o !== 3'd2 || got !== exp_v) begin
        errors++;
        $display("FAIL integ%0d state=%0d pot=%0d required state=2 pot=%0d", k, a.state_o, got, exp_v);
      end
      mpot = exp_v;
      @(negedge clk);
      checks++;
      if (mpot >= 100) begin
        if (a.out_req !== 1'b1 || a.potential !== 16'd0 || a.state_o !== 3'd3) begin
          errors++;
          $display("FAIL spike%0d oreq=%b pot=%0d state=%0d required 1/0/3", k, a.out_req, a.potential, a.state_o);
        end
        mpot = 0;
      end else if (a.out_req !== 1'b0 || a.state_o !== 3'd0) begin
        errors++;
        $display("FAIL nospike%0d oreq=%b state=%0d required 0/0", k, a.out_req, a.state_o);
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (a.out_req !== 1'b1) begin
      errors++;
      $display("FAIL fire_hold oreq=%b required 1", a.out_req);
    end
    a.out_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (a.out_req !== 1'b0 || a.state_o !== 3'd4) begin
      errors++;
      $display("FAIL fire_rtz oreq=%b state=%0d required 0/4", a.out_req, a.state_o);
    end
    a.out_ack = 1'b0;
    @(negedge clk);
    n = 0;
    while (a.state_o == 3'd5 && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 3 || a.state_o !== 3'd0) begin
      errors++;
      $display("FAIL refract_len cycles=%0d state=%0d required 3/0", n, a.state_o);
    end
  endtask

  task automatic test_join;
    a_send(4'hf, {8'd20, 8'd30, 8'd30, 8'd30}, ok);
    checks++;
    if (!ok || a.in_ack !== 4'hf || a.state_o !== 3'd1) begin
      errors++;
      $display("FAIL join_ack ack=%b state=%0d required 1111/1", a.in_ack, a.state_o);
    end
    q_exp.push_back(integ(0, 110, 4, 16));
    a.in_req = 4'd0;
    @(negedge clk);
    exp_v = q_exp.pop_front();
    got = longint'($signed(a.potential));
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL join_pot pot=%0d required %0d", got, exp_v);
    end
    @(negedge clk);
    checks++;
    if (a.out_req !== 1'b1 || a.potential !== 16'd0) begin
      errors++;
      $display("FAIL join_spike oreq=%b pot=%0d required 1/0", a.out_req, a.potential);
    end
    a.out_ack = 1'b1;
    @(negedge clk);
    a.out_ack = 1'b0;
    a_wait(3'd0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL join_idle state=%0d required 0", a.state_o);
    end
  endtask

  task automatic test_refract;
    bit bad;
    int n;
    a_send(4'b0001, 32'd120, ok);
    a.in_req = 4'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || a.out_req !== 1'b1) begin
      errors++;
      $display("FAIL rf_spike oreq=%b required 1", a.out_req);
    end
    a.out_ack = 1'b1;
    @(negedge clk);
    a.out_ack = 1'b0;
    a_wait(3'd5, ok);
    a.in_weight = {16'd0, 8'd5, 8'd0};
    a.in_req[1] = 1'b1;
    bad = 1'b0;
    n = 0;
    while (a.state_o == 3'd5 && n < 20) begin
      if (a.in_ack[1] !== 1'b0) bad = 1'b1;
      n++;
      @(negedge clk);
    end
    checks++;
    if (!ok || bad || n == 0 || a.in_ack[1] !== 1'b0 || a.state_o !== 3'd0) begin
      errors++;
      $display("FAIL rf_block early_ack=%b ack1=%b state=%0d required 0/0/0", bad, a.in_ack[1], a.state_o);
    end
    @(negedge clk);
    checks++;
    if (a.in_ack[1] !== 1'b1 || a.state_o !== 3'd1) begin
      errors++;
      $display("FAIL rf_accept ack1=%b state=%0d required 1/1", a.in_ack[1], a.state_o);
    end
    q_exp.push_back(integ(0, 5, 4, 16));
    a.in_req = 4'd0;
    @(negedge clk);
    exp_v = q_exp.pop_front();
    got = longint'($signed(a.potential));
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL rf_pot pot=%0d required %0d", got, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_saturation;
    longint w;
    mpot = 0;
    for (int k = 0; k < 4; k++) begin
      w = k < 3 ? -128 : 127;
      s_send(8'(w), ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL sat_accept%0d ack=%b required 1", k, s.in_ack[0]);
      end
      q_exp.push_back(integ(mpot, w, 4, 8));
      s.in_req = 4'd0;
      @(negedge clk);
      exp_v = q_exp.pop_front();
      got = longint'($signed(s.potential));
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL sat_pot%0d pot=%0d required %0d", k, got, exp_v);
      end
      mpot = exp_v;
      @(negedge clk);
      checks++;
      if (s.out_req !== 1'b0 || s.state_o !== 3'd0) begin
        errors++;
        $display("FAIL sat_nospike%0d oreq=%b state=%0d required 0/0", k, s.out_req, s.state_o);
      end
    end
  endtask

  task automatic test_leak;
    logic [7:0] w [3];
    w[0] = 8'd80;
    w[1] = 8'd0;
    w[2] = 8'd0;
    mpot = 0;
    for (int k = 0; k < 3; k++) begin
      l_send(w[k], ok);
      q_exp.push_back(integ(mpot, longint'(w[k]), 2, 16));
      l.in_req = 4'd0;
      @(negedge clk);
      exp_v = q_exp.pop_front();
      got = longint'($signed(l.potential));
      checks++;
      if (!ok || got !== exp_v) begin
        errors++;
        $display("FAIL leak_pot%0d pot=%0d required %0d", k, got, exp_v);
      end
      mpot = exp_v;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_fire;
    a_send(4'b0001, 32'd120, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || a.out_req !== 1'b1 || a.in_ack[0] !== 1'b1 || a.state_o !== 3'd3) begin
      errors++;
      $display("FAIL rst_pre oreq=%b ack0=%b state=%0d required 1/1/3", a.out_req, a.in_ack[0], a.state_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (a.out_req !== 1'b0 || a.in_ack !== 4'd0 || a.potential !== 16'd0 || a.state_o !== 3'd0) begin
      errors++;
      $display("FAIL rst_async oreq=%b ack=%b pot=%0d state=%0d required 0/0/0/0", a.out_req, a.in_ack, a.potential, a.state_o);
    end
    a.in_req = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (a.state_o !== 3'd0 || a.out_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_release state=%0d oreq=%b required 0/0", a.state_o, a.out_req);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a.in_req = '0; a.in_weight = '0; a.out_ack = 1'b0;
    s.in_req = '0; s.in_weight = '0; s.out_ack = 1'b0;
    l.in_req = '0; l.in_weight = '0; l.out_ack = 1'b0;
    test_reset;
    test_integrate_fire;
    test_join;
    test_refract;
    test_saturation;
    test_leak;
    test_reset_fire;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
